// File: rtl/ir_packet_receiver.sv
// IR remote-car packet decoder: start, car-select and four command-bit bursts,
// with the last good command and an error count readable over a small bus.
module ir_packet_receiver #(
  parameter logic [7:0] BaseAddr           = 8'hA0,
  parameter int         StartBurstSize     = 88,
  parameter int         CarSelectBurstSize = 22,
  parameter int         AssertBurstSize    = 44,
  parameter int         DeassertBurstSize  = 22,
  parameter int         Tolerance          = 4,
  parameter int         EdgeTimeout        = 4000,
  parameter int         MaxGapClocks       = 200000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       IR_IN,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic [3:0] CMD_OUT,
  output logic       CMD_VALID,
  output logic       PACKET_RX
);
  localparam int IW = $clog2(EdgeTimeout + 1);
  localparam int GW = $clog2(MaxGapClocks + 1);
  localparam logic [7:0] START_LO = 8'(StartBurstSize - Tolerance);
  localparam logic [7:0] START_HI = 8'(StartBurstSize + Tolerance);
  localparam logic [7:0] CSEL_LO  = 8'(CarSelectBurstSize - Tolerance);
  localparam logic [7:0] CSEL_HI  = 8'(CarSelectBurstSize + Tolerance);
  localparam logic [7:0] BIT_LO   = 8'(DeassertBurstSize - Tolerance);
  localparam logic [7:0] BIT_HI   = 8'(AssertBurstSize + Tolerance);
  localparam logic [7:0] BIT_MID  = 8'((AssertBurstSize + DeassertBurstSize) / 2);
  localparam logic [7:0] ADDR_ERR = BaseAddr + 8'd1;

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

  state_t          state, state_nxt;
  logic [2:0]      ir_sync;
  logic            ir_edge;
  logic [7:0]      pulse_cnt;
  logic [IW-1:0]   idle_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [2:0]      field;
  logic [3:0]      shift;
  logic [7:0]      err_cnt;
  logic [7:0]      rd_data;
  logic            rd_en;
  logic            burst_end, in_win, bit_one, adv, done_evt, err_evt;
  logic            wr_cmd, wr_err, rd_hit;

  assign ir_edge = ir_sync[1] & ~ir_sync[2];
  assign bit_one = pulse_cnt >= BIT_MID;
  assign in_win  = (field == 3'd0) ? (pulse_cnt >= START_LO && pulse_cnt <= START_HI) :
                   (field == 3'd1) ? (pulse_cnt >= CSEL_LO  && pulse_cnt <= CSEL_HI)  :
                                     (pulse_cnt >= BIT_LO   && pulse_cnt <= BIT_HI);
  assign burst_end = (state == S_BURST) && (idle_cnt == IW'(EdgeTimeout));

  assign wr_cmd = BUS_WE && (BUS_ADDR == BaseAddr);
  assign wr_err = BUS_WE && (BUS_ADDR == ADDR_ERR);
  assign rd_hit = !BUS_WE && (BUS_ADDR == BaseAddr || BUS_ADDR == ADDR_ERR);

  always_comb begin
    state_nxt = state;
    adv       = 1'b0;
    done_evt  = 1'b0;
    err_evt   = 1'b0;
    case (state)
      S_IDLE:  if (ir_edge) state_nxt = S_BURST;
      S_BURST: if (burst_end) begin
        if (!in_win) begin
          err_evt   = 1'b1;
          state_nxt = S_IDLE;
        end else if (field == 3'd5) begin
          done_evt  = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          adv       = 1'b1;
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        // silence timeout beats a late edge arriving on the same cycle
        if (gap_cnt == GW'(MaxGapClocks)) begin
          err_evt   = 1'b1;
          state_nxt = S_IDLE;
        end else if (ir_edge) begin
          state_nxt = S_BURST;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      ir_sync   <= '0;
      pulse_cnt <= '0;
      idle_cnt  <= '0;
      gap_cnt   <= '0;
      field     <= '0;
      shift     <= '0;
    end else begin
      state   <= state_nxt;
      ir_sync <= {ir_sync[1:0], IR_IN};
      case (state)
        S_IDLE: if (ir_edge) begin
          pulse_cnt <= 8'd1;
          idle_cnt  <= '0;
          field     <= '0;
          shift     <= '0;
        end
        S_BURST: begin
          if (burst_end) begin
            if (field >= 3'd2) shift <= {shift[2:0], bit_one};
            if (adv) begin
              field   <= field + 3'd1;
              gap_cnt <= '0;
            end
          end else if (ir_edge) begin
            pulse_cnt <= (pulse_cnt == 8'hFF) ? pulse_cnt : pulse_cnt + 8'd1;
            idle_cnt  <= '0;
          end else begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt + GW'(1);
          if (ir_edge) begin
            pulse_cnt <= 8'd1;
            idle_cnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      CMD_OUT   <= '0;
      CMD_VALID <= 1'b0;
      PACKET_RX <= 1'b0;
      err_cnt   <= '0;
      rd_data   <= '0;
      rd_en     <= 1'b0;
    end else begin
      PACKET_RX <= done_evt;
      if (done_evt) begin
        CMD_OUT   <= {shift[2:0], bit_one};
        CMD_VALID <= 1'b1;
      end else if (wr_cmd) begin
        CMD_VALID <= 1'b0;
      end
      // a clear landing with a new error leaves that error counted
      if (err_evt)     err_cnt <= wr_err ? 8'd1 : ((err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1);
      else if (wr_err) err_cnt <= '0;
      rd_en <= rd_hit;
      if (rd_hit) rd_data <= (BUS_ADDR == BaseAddr) ? {CMD_VALID, 3'b000, CMD_OUT} : err_cnt;
    end
  end

  assign BUS_DATA = rd_en ? rd_data : 8'bzzzz_zzzz;
endmodule
